aes_key_expansion: RTL and testbench

AES_KEY_EXPANSION -- requirements
Module: aes_key_expansion

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_sbox.sv | 21 ++
 rtl/aes_key_expansion.sv | 98 +++++++++
 tb/tb_aes_key_expansion.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule FSM states, round count and the Rcon table.
// The cipher datapath and the key expansion both import this package.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int NUM_KEYS   = NUM_ROUNDS + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_READY
  } key_state_e;

  // Rcon for rounds 1..10, round 1 in the top byte.
  localparam logic [8*NUM_ROUNDS-1:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    if (round >= 4'd1 && round <= 4'(NUM_ROUNDS))
      return RCON_TABLE[8*(NUM_ROUNDS - int'(round)) +: 8];
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, pure combinational lookup; also instantiated by the cipher datapath.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0x00 sits in the top byte, so the bit offset of entry x is 8 * (255 - x).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: loads a cipher key and derives one full round key per cycle
// into an 11-entry register file readable by the cipher datapath.
module aes_key_expansion
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  input  logic [3:0]   read_addr,
  output logic [127:0] round_key_input,
  output logic [127:0] round_key_0,
  output logic [127:0] round_key_10,
  output logic         key_busy,
  output logic         key_ready
);

  logic [127:0] rk [NUM_KEYS];
  logic [3:0]   round_cnt;
  key_state_e   state;

  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  w0, w1, w2, w3;

  // round_cnt names the key being produced, so its predecessor is rk[round_cnt-1].
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    prev_key = rk[0];
    for (int i = 1; i < NUM_KEYS; i++)
      if (round_cnt == 4'(i)) prev_key = rk[i-1];
  end

  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte (rot_word[8*g +: 8]),
      .out_byte(sub_word[8*g +: 8])
    );
  end

  assign w0       = prev_key[127:96] ^ sub_word ^ {rcon(round_cnt), 24'h0};
  assign w1       = prev_key[95:64]  ^ w0;
  assign w2       = prev_key[63:32]  ^ w1;
  assign w3       = prev_key[31:0]   ^ w2;
  assign next_key = {w0, w1, w2, w3};

  always_comb begin
    round_key_input = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (read_addr == 4'(i)) round_key_input = rk[i];
  end

  assign round_key_0  = rk[0];
  assign round_key_10 = rk[NUM_ROUNDS];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state     <= ST_IDLE;
      round_cnt <= '0;
      key_busy  <= 1'b0;
      key_ready <= 1'b0;
      // NOTE: the key file is flops, not RAM, and must read as zero during reset, so it is reset too.
      for (int i = 0; i < NUM_KEYS; i++) rk[i] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_READY: begin
          if (key_valid) begin
            rk[0]     <= key_in;
            round_cnt <= 4'd1;
            key_ready <= 1'b0;
            key_busy  <= 1'b1;
            state     <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          // key_valid is deliberately not looked at here: a new key waits for READY.
          for (int i = 1; i < NUM_KEYS; i++)
            if (round_cnt == 4'(i)) rk[i] <= next_key;
          if (round_cnt == 4'(NUM_ROUNDS)) begin
            round_cnt <= '0;
            key_busy  <= 1'b0;
            key_ready <= 1'b1;
            state     <= ST_READY;
          end else begin
            round_cnt <= round_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for aes_key_expansion using FIPS-197 and all-zero key vectors,
// a read-address sweep table and hand-written restart / ignore / reset sequences.
module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         key_valid;
  logic [127:0] key_in;
  logic [3:0]   read_addr;
  logic [127:0] round_key_input;
  logic [127:0] round_key_0;
  logic [127:0] round_key_10;
  logic         key_busy;
  logic         key_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
  } sweep_vec_t;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] JUNK_KEY  = 128'hdeadbeef0123456789abcdeffeedface;

  logic [127:0] fips_rk [11];
  sweep_vec_t   sweep [16];

  aes_key_expansion dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .key_valid      (key_valid),
    .key_in         (key_in),
    .read_addr      (read_addr),
    .round_key_input(round_key_input),
    .round_key_0    (round_key_0),
    .round_key_10   (round_key_10),
    .key_busy       (key_busy),
    .key_ready      (key_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge. Loads key, optionally pulses a junk key_valid after inject_at
  // rising edges, and returns how many rising edges (load edge included) until key_ready.
  task automatic load_and_wait(input logic [127:0] key, input int inject_at, output int edges);
    key_in    = key;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_in    = ~key;
    edges     = 1;
    check("busy_after_load", 128'(key_busy), 128'(1));
    check("ready_low_after_load", 128'(key_ready), 128'(0));
    while (!key_ready && edges < 40) begin
      check("busy_ready_exclusive", 128'(key_busy & key_ready), 128'(0));
      if (edges == inject_at) begin
        key_in    = JUNK_KEY;
        key_valid = 1'b1;
      end
      @(negedge clk);
      key_valid = 1'b0;
      edges++;
    end
    check("latency_edges", 128'(edges), 128'(11));
    check("busy_low_when_ready", 128'(key_busy), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;

    fips_rk[0]  = FIPS_KEY;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 16; i++) begin
      sweep[i].addr = 4'(i);
      sweep[i].exp  = (i <= 10) ? fips_rk[i] : 128'h0;
    end

    // Reset: all outputs zero, block idle afterwards.
    n_rst     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    read_addr = 4'd5;
    #2 n_rst = 1'b1;
    #1;
    check("rst_round_key_input", round_key_input, 128'h0);
    check("rst_round_key_0", round_key_0, 128'h0);
    check("rst_round_key_10", round_key_10, 128'h0);
    check("rst_key_busy", 128'(key_busy), 128'(0));
    check("rst_key_ready", 128'(key_ready), 128'(0));
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_key_ready", 128'(key_ready), 128'(0));
    check("idle_key_busy", 128'(key_busy), 128'(0));

    // FIPS-197 key from IDLE.
    load_and_wait(FIPS_KEY, 0, edges);
    check("fips_round_key_0", round_key_0, FIPS_KEY);
    check("fips_round_key_10", round_key_10, fips_rk[10]);

    // Address sweep in READY.
    for (int i = 0; i < 16; i++) begin
      read_addr = sweep[i].addr;
      #1;
      check($sformatf("sweep_addr_%0d", i), round_key_input, sweep[i].exp);
    end
    @(negedge clk);

    // Restart from READY with the all-zero key.
    load_and_wait(128'h0, 0, edges);
    check("zero_round_key_10", round_key_10, ZERO_RK10);
    check("zero_round_key_0", round_key_0, 128'h0);
    read_addr = 4'd1;
    #1 check("zero_rk1", round_key_input, ZERO_RK1);
    @(negedge clk);

    // key_valid mid-expansion must be ignored.
    load_and_wait(FIPS_KEY, 5, edges);
    check("ignore_round_key_0", round_key_0, FIPS_KEY);
    check("ignore_round_key_10", round_key_10, fips_rk[10]);
    read_addr = 4'd1;
    #1 check("ignore_rk1", round_key_input, fips_rk[1]);
    @(negedge clk);

    // Reset in the middle of an expansion, asserted away from any clock edge.
    key_in    = 128'h0;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_abort_busy", 128'(key_busy), 128'(1));
    #2 n_rst = 1'b1;
    #1;
    check("abort_round_key_input", round_key_input, 128'h0);
    check("abort_round_key_0", round_key_0, 128'h0);
    check("abort_round_key_10", round_key_10, 128'h0);
    check("abort_key_busy", 128'(key_busy), 128'(0));
    check("abort_key_ready", 128'(key_ready), 128'(0));
    @(negedge clk);
    #2 n_rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("post_abort_ready", 128'(key_ready), 128'(0));
      check("post_abort_busy", 128'(key_busy), 128'(0));
    end
    check("post_abort_rk1", round_key_input, 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
